// File: rtl/qos_packet_arbiter.sv
// qos_packet_arbiter: N-to-1 stream arbiter with QoS priority, round-robin
// tie-break, packet lock, anti-starvation aging and a registered output slice.
module qos_packet_arbiter #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 2,
  parameter int T_ID___WIDTH = $clog2(STREAM_COUNT),
  parameter int AGE_LIMIT    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_DATA_WIDTH-1:0] s_data_i  [STREAM_COUNT],
  input  logic [T_QOS__WIDTH-1:0] s_qos_i   [STREAM_COUNT],
  input  logic [STREAM_COUNT-1:0] s_last_i,
  input  logic [STREAM_COUNT-1:0] s_valid_i,
  output logic [STREAM_COUNT-1:0] s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic [T_QOS__WIDTH-1:0] m_qos_o,
  output logic [T_ID___WIDTH-1:0] m_id_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int AW = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                  r_state, w_state_nxt;
  logic [T_ID___WIDTH-1:0] r_lock_id;
  logic [T_ID___WIDTH-1:0] r_rr_ptr;
  logic [AW-1:0]           r_age [STREAM_COUNT];

  logic [T_QOS__WIDTH:0]   w_eff [STREAM_COUNT];
  logic [T_QOS__WIDTH:0]   w_best;
  logic [T_ID___WIDTH-1:0] w_win_id;
  logic                    w_win_vld;
  logic [T_ID___WIDTH-1:0] w_sel_id;
  logic                    w_sel_en;
  logic                    w_sel_last;
  logic                    w_out_free;
  logic                    w_accept;

  logic [T_DATA_WIDTH-1:0] r_m_data;
  logic [T_QOS__WIDTH-1:0] r_m_qos;
  logic [T_ID___WIDTH-1:0] r_m_id;
  logic                    r_m_last;
  logic                    r_m_valid;

  // Effective priority: a stream that reached the age limit gets an extra MSB.
  always_comb begin
    for (int unsigned i = 0; i < STREAM_COUNT; i++) begin
      w_eff[i] = {1'b0, s_qos_i[i]};
      if (AGE_LIMIT != 0 && int'(r_age[i]) == AGE_LIMIT)
        w_eff[i] = {1'b1, s_qos_i[i]};
    end
  end

  // Scan from the stream after rr_ptr; only a strictly higher priority
  // displaces an earlier candidate, which yields the round-robin tie-break.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_id  = '0;
    w_best    = '0;
    for (int unsigned k = 1; k <= STREAM_COUNT; k++) begin
      int unsigned idx;
      idx = (32'(r_rr_ptr) + k) % 32'(STREAM_COUNT);
      if (s_valid_i[idx] && (!w_win_vld || w_eff[idx] > w_best)) begin
        w_win_vld = 1'b1;
        w_win_id  = idx[T_ID___WIDTH-1:0];
        w_best    = w_eff[idx];
      end
    end
  end

  // Stream selection, ready generation and FSM next state.
  always_comb begin
    w_out_free  = (~r_m_valid | m_ready_i) & ~rst;
    w_sel_id    = (r_state == LOCK) ? r_lock_id : w_win_id;
    w_sel_en    = (r_state == LOCK) | w_win_vld;
    w_sel_last  = s_last_i[w_sel_id];
    w_accept    = w_sel_en & w_out_free & s_valid_i[w_sel_id];
    s_ready_o   = '0;
    if (w_sel_en && w_out_free)
      s_ready_o[w_sel_id] = 1'b1;
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept && !w_sel_last) w_state_nxt = LOCK;
      LOCK: if (w_accept &&  w_sel_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, lock owner and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lock_id <= '0;
      r_rr_ptr  <= T_ID___WIDTH'(STREAM_COUNT - 1);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_accept)
        r_lock_id <= w_win_id;
      if (w_accept && w_sel_last)
        r_rr_ptr <= w_sel_id;
    end
  end

  // Aging: updated only when a first beat is committed in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < STREAM_COUNT; i++)
        r_age[i] <= '0;
    end else if (AGE_LIMIT > 0 && r_state == IDLE && w_accept) begin
      for (int unsigned i = 0; i < STREAM_COUNT; i++) begin
        if (i == 32'(w_win_id))
          r_age[i] <= '0;
        else if (s_valid_i[i] && int'(r_age[i]) < AGE_LIMIT)
          r_age[i] <= r_age[i] + 1'b1;
      end
    end
  end

  // Output slice: load on accept, drop valid only when drained with no load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_data  <= '0;
      r_m_qos   <= '0;
      r_m_id    <= '0;
      r_m_last  <= 1'b0;
      r_m_valid <= 1'b0;
    end else if (w_accept) begin
      r_m_data  <= s_data_i[w_sel_id];
      r_m_qos   <= s_qos_i[w_sel_id];
      r_m_id    <= w_sel_id;
      r_m_last  <= w_sel_last;
      r_m_valid <= 1'b1;
    end else if (m_ready_i) begin
      r_m_valid <= 1'b0;
    end
  end

  assign m_data_o  = r_m_data;
  assign m_qos_o   = r_m_qos;
  assign m_id_o    = r_m_id;
  assign m_last_o  = r_m_last;
  assign m_valid_o = r_m_valid;

endmodule

// File: tb/tb_qos_packet_arbiter.sv
// Directed bench for qos_packet_arbiter (4 streams, AGE_LIMIT=2) with a
// scoreboard queue of accepted beats compared against the output slice.
module tb_qos_packet_arbiter;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic [3:0] qos;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sd [4];
  logic [3:0] sq [4];
  logic [3:0] sl;
  logic [3:0] sv;
  logic [3:0] s_ready;
  logic [7:0] m_data;
  logic [3:0] m_qos;
  logic [1:0] m_id;
  logic       m_last;
  logic       m_valid;
  logic       mr;

  int    vectors     = 0;
  int    miscompares = 0;
  int    seq         = 0;
  beat_t q [$];

  always #5 clk = ~clk;

  qos_packet_arbiter #(
    .T_DATA_WIDTH(8),
    .T_QOS__WIDTH(4),
    .STREAM_COUNT(4),
    .T_ID___WIDTH(2),
    .AGE_LIMIT   (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data_i (sd),
    .s_qos_i  (sq),
    .s_last_i (sl),
    .s_valid_i(sv),
    .s_ready_o(s_ready),
    .m_data_o (m_data),
    .m_qos_o  (m_qos),
    .m_id_o   (m_id),
    .m_last_o (m_last),
    .m_valid_o(m_valid),
    .m_ready_i(mr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: called just after a falling edge with inputs already set.
  task automatic step(input logic [3:0] exp_rdy, input string tag);
    beat_t b;
    seq++;
    for (int i = 0; i < 4; i++) sd[i] = 8'((i << 6) | (seq & 63));
    #1;
    check({tag, ".m_valid"}, 32'(m_valid), 32'(q.size() != 0));
    if (m_valid && q.size() != 0) begin
      check({tag, ".m_id"},   32'(m_id),   32'(q[0].id));
      check({tag, ".m_data"}, 32'(m_data), 32'(q[0].data));
      check({tag, ".m_qos"},  32'(m_qos),  32'(q[0].qos));
      check({tag, ".m_last"}, 32'(m_last), 32'(q[0].last));
      if (mr) void'(q.pop_front());
    end
    check({tag, ".s_ready"}, 32'(s_ready), 32'(exp_rdy));
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (sv[i] && exp_rdy[i]) begin
          b.id = 2'(i); b.data = sd[i]; b.qos = sq[i]; b.last = sl[i];
          q.push_back(b);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    q.delete();
    check("rst.m_data",  32'(m_data),  32'h0);
    check("rst.m_qos",   32'(m_qos),   32'h0);
    check("rst.m_id",    32'(m_id),    32'h0);
    check("rst.m_last",  32'(m_last),  32'h0);
    step(4'b0000, "rst");
    rst = 1'b0;
  endtask

  task automatic drain();
    sv = 4'b0000;
    step(4'b0000, "drain1");
    step(4'b0000, "drain2");
  endtask

  initial begin
    logic [3:0] rr_exp [6];
    logic [3:0] age_exp [6];
    rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100};
    age_exp = '{4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0010};

    rst = 1'b1; mr = 1'b1; sv = 4'b1111; sl = 4'b1111;
    for (int i = 0; i < 4; i++) begin sq[i] = '0; sd[i] = '0; end
    @(negedge clk);

    // Reset with all streams valid; first grant goes to stream 0.
    do_reset();
    step(4'b0001, "t1.first");
    step(4'b0010, "t1.second");
    drain();

    // QoS: stream 2 (qos 9) beats stream 0 (qos 2).
    do_reset();
    sv = 4'b0101; sl = 4'b1111; sq[0] = 4'd2; sq[2] = 4'd9;
    step(4'b0100, "t2.grant");
    sv = 4'b0000;
    step(4'b0000, "t2.out");
    check("t2.empty", 32'(q.size()), 32'd0);
    drain();

    // Lock: stream 1 3-beat packet holds through qos change and valid gap.
    do_reset();
    for (int i = 0; i < 4; i++) sq[i] = '0;
    sv = 4'b0011; sl = 4'b0001; sq[1] = 4'd5;
    step(4'b0010, "t3.beat1");
    sq[0] = 4'd15;
    step(4'b0010, "t3.beat2");
    sv = 4'b0001;
    step(4'b0010, "t3.gap");
    sv = 4'b0011; sl = 4'b0011;
    step(4'b0010, "t3.beat3");
    sv = 4'b0001;
    step(4'b0001, "t3.s0");
    drain();

    // Round robin among three equal-qos streams, then 5 cycles backpressure.
    do_reset();
    for (int i = 0; i < 4; i++) sq[i] = 4'd3;
    sv = 4'b0111; sl = 4'b1111; mr = 1'b1;
    for (int n = 0; n < 6; n++) step(rr_exp[n], "t4.rr");
    mr = 1'b0;
    for (int n = 0; n < 5; n++) step(4'b0000, "t4.stall");
    mr = 1'b1;
    step(4'b0001, "t4.resume0");
    step(4'b0010, "t4.resume1");
    drain();
    check("t4.empty", 32'(q.size()), 32'd0);

    // Aging: low-priority stream 1 wins every third packet.
    do_reset();
    sq[0] = 4'd15; sq[1] = 4'd0; sv = 4'b0011; sl = 4'b1111;
    for (int n = 0; n < 6; n++) step(age_exp[n], "t5.age");
    drain();

    // Mid-packet reset: build age on stream 2, start a 4-beat packet on
    // stream 0, reset during beat 2, then confirm IDLE and cleared ages.
    do_reset();
    sq[0] = 4'd0; sq[1] = 4'd15; sq[2] = 4'd0; sv = 4'b0110; sl = 4'b1111;
    step(4'b0010, "t6.pre0");
    step(4'b0010, "t6.pre1");
    sv = 4'b0001; sl = 4'b0000;
    step(4'b0001, "t6.beat1");
    rst = 1'b1;
    step(4'b0000, "t6.rst");
    rst = 1'b0;
    q.delete();
    check("t6.m_valid", 32'(m_valid), 32'h0);
    sv = 4'b0010; sl = 4'b1111;
    step(4'b0010, "t6.idle");
    sv = 4'b0110;
    step(4'b0010, "t6.ages");
    drain();
    check("t6.empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
